// File: rtl/stoch_pkg.sv
// stoch_pkg: shared state encoding, LFSR constants and index-width helper for stochastic nodes
package stoch_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, INIT = 2'b01, RUN = 2'b10} state_t;
    localparam int LFSR_W = 16;
    // Taps 16,14,13,11 expressed as a bit mask over the 16-bit register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, shifts left with feedback into bit 0, free-running out of reset
module lfsr16 import stoch_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [LFSR_W-1:0] lfsr
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    assign lfsr = lfsr_q;
endmodule

// File: rtl/em_edge_ctrl.sv
// em_edge_ctrl: pre-loads the edge memory with channel bits, then gates it on regenerative states
module em_edge_ctrl import stoch_pkg::*; #(
    parameter int              N    = 8,
    parameter int              DI   = 2,
    parameter int              W    = 8,
    parameter logic [15:0]     SEED = 16'hACE1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [W-1:0]  P,
    input  logic [DI-1:0] IN_BITS,
    input  logic          EM_OUT,
    output logic          EM_IN,
    output logic          EM_EN,
    output logic [N-1:0]  EM_SEL,
    output logic          OUT,
    output logic          READY
);
    localparam int LN = clog2(N);
    state_t          state_q, state_d;
    logic [LN-1:0]   cnt_q, cnt_d, sel_q, sel_d;
    logic            out_q, out_d;
    logic [LFSR_W-1:0] lfsr;
    logic [W-1:0]    rnd;
    logic [LN-1:0]   idx;
    logic            agree;
    logic            lfsr_unused;

    lfsr16 #(.SEED(SEED)) u_lfsr (.CLK(CLK), .RESET(RESET), .lfsr(lfsr));

    assign rnd         = lfsr[W-1:0];
    assign idx         = lfsr[LFSR_W-1 -: LN];
    assign lfsr_unused = ^lfsr;
    assign agree       = (&IN_BITS) | (~|IN_BITS);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        out_d   = 1'b0;
        EM_EN   = 1'b0;
        EM_IN   = 1'b0;
        if (state_q == INIT) begin
            EM_EN   = 1'b1;
            EM_IN   = rnd < P;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LN'(N - 1)) ? RUN : INIT;
        end
        if (state_q == RUN) begin
            EM_EN = agree;
            EM_IN = IN_BITS[0];
            out_d = agree ? IN_BITS[0] : EM_OUT;
        end
        // A restart wins over everything; OUT keeps its value for this one edge
        if (START) begin
            state_d = INIT;
            cnt_d   = '0;
            out_d   = out_q;
        end
        sel_d = (state_d == RUN) ? idx : '0;
    end

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end

    assign EM_SEL = N'(sel_q);
    assign OUT    = out_q;
    assign READY  = (state_q == RUN);
endmodule

// File: tb/tb_em_edge_ctrl.sv
// tb_em_edge_ctrl: scoreboard bench for em_edge_ctrl (N=8, DI=2, W=8)
module tb_em_edge_ctrl;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic [7:0] P = 8'h00;
    logic [1:0] IN_BITS = 2'b00;
    logic       EM_OUT = 1'b0;
    logic       EM_IN, EM_EN, OUT, READY;
    logic [7:0] EM_SEL;

    em_edge_ctrl #(.N(8), .DI(2), .W(8), .SEED(16'hACE1)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .P(P), .IN_BITS(IN_BITS),
        .EM_OUT(EM_OUT), .EM_IN(EM_IN), .EM_EN(EM_EN), .EM_SEL(EM_SEL),
        .OUT(OUT), .READY(READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       en;
        logic       din;
        logic       rdy;
        logic       out;
        logic [7:0] sel;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [15:0] ref_lfsr, prev_lfsr;
    always @(posedge CLK or negedge RESET)
        if (!RESET) begin
            ref_lfsr  <= 16'hACE1;
            prev_lfsr <= 16'hACE1;
        end else begin
            prev_lfsr <= ref_lfsr;
            ref_lfsr  <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
        end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK)
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".EM_EN"},  16'(EM_EN),  16'(e.en));
            chk({e.name, ".EM_IN"},  16'(EM_IN),  16'(e.din));
            chk({e.name, ".READY"},  16'(READY),  16'(e.rdy));
            chk({e.name, ".OUT"},    16'(OUT),    16'(e.out));
            chk({e.name, ".EM_SEL"}, 16'(EM_SEL), 16'(e.sel));
        end

    // ph: 0=IDLE/reset, 1=INIT, 2=RUN (state during this cycle); eout = expected OUT this cycle
    task automatic step(input string nm, input int ph, input bit st, input logic [7:0] p,
                        input logic [1:0] ib, input bit eo, input bit eout);
        exp_t e;
        logic agree;
        @(posedge CLK);
        #1;
        START = st; P = p; IN_BITS = ib; EM_OUT = eo;
        agree  = (&ib) | (~|ib);
        e.name = nm;
        e.en   = (ph == 1) ? 1'b1 : (ph == 2) ? agree : 1'b0;
        e.din  = (ph == 1) ? (ref_lfsr[7:0] < p) : (ph == 2) ? ib[0] : 1'b0;
        e.rdy  = (ph == 2);
        e.out  = eout;
        e.sel  = (ph == 2) ? {5'b0, prev_lfsr[15:13]} : 8'h00;
        q.push_back(e);
    endtask

    task automatic async_reset(input string nm);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        START = 1'b0;
        #1;
        chk({nm, ".EM_EN"},  16'(EM_EN),  16'h0);
        chk({nm, ".OUT"},    16'(OUT),    16'h0);
        chk({nm, ".READY"},  16'(READY),  16'h0);
        chk({nm, ".EM_SEL"}, 16'(EM_SEL), 16'h0);
        chk({nm, ".lfsr"},   dut.u_lfsr.lfsr, 16'hACE1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) step("reset", 0, 0, 8'h00, 2'b00, 0, 0);
        RESET = 1'b1;
        for (int i = 0; i < 20; i++) step("idle", 0, 0, 8'h00, 2'b11, 1, 0);
        step("start_p00", 0, 1, 8'h00, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) step("init_p00", 1, 0, 8'h00, 2'b00, 0, 0);
        step("run_11", 2, 0, 8'h00, 2'b11, 0, 0);
        step("run_00", 2, 0, 8'h00, 2'b00, 0, 1);
        step("run_01_em1", 2, 0, 8'h00, 2'b01, 1, 0);
        step("run_10_em0", 2, 0, 8'h00, 2'b10, 0, 1);
        step("run_11_b", 2, 0, 8'h00, 2'b11, 1, 0);
        step("run_restart", 2, 1, 8'hFF, 2'b01, 0, 1);
        step("init_pff_hold", 1, 0, 8'hFF, 2'b00, 0, 1);
        for (int i = 0; i < 6; i++) step("init_pff", 1, 0, 8'hFF, 2'b00, 0, 0);
        step("init_last_restart", 1, 1, 8'hFF, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) step("init_again", 1, 0, 8'hFF, 2'b00, 0, 0);
        step("run_after_restart", 2, 0, 8'h00, 2'b00, 0, 0);
        step("run_01_sel", 2, 0, 8'h00, 2'b01, 1, 0);
        step("run_10_sel", 2, 0, 8'h00, 2'b10, 0, 1);
        step("run_01_sel2", 2, 1, 8'h80, 2'b01, 1, 0);
        for (int i = 0; i < 3; i++) step("init_p80", 1, 0, 8'h80, 2'b00, 0, 0);
        async_reset("rst_mid_init");
        step("post_rst_idle", 0, 0, 8'h80, 2'b00, 0, 0);
        step("post_rst_start", 0, 1, 8'h80, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) step("init_p80_seed", 1, 0, 8'h80, 2'b00, 0, 0);
        step("run2_11", 2, 0, 8'h00, 2'b11, 0, 0);
        step("run2_11_b", 2, 0, 8'h00, 2'b11, 0, 1);
        async_reset("rst_mid_run");
        step("final_idle", 0, 0, 8'h00, 2'b00, 0, 0);
        step("final_idle2", 0, 0, 8'h00, 2'b11, 0, 0);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/em_edge_ctrl.md
Name: em_edge_ctrl

Overview:
Variable-node edge controller. Sits directly upstream of the edge-memory shift register and drives its IN, EN and SEL inputs. It pre-loads the edge memory with channel-probability bits after start. In run mode it gates EN on regenerative (all-agree) states, and it produces the node's stochastic output bit by choosing between the fresh agreed bit and the edge-memory output on hold states.

Parameters:
N, 8, edge-memory depth; power of two, >=2; must match the downstream EM N
DI, 2, number of incoming stochastic edge bits (node degree minus one), >=1
W, 8, channel-probability width in bits; 1..16
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
CLK  in  1  system clock; all state updates on the rising edge
RESET  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse that begins (or restarts) initialisation
P  in  W  channel probability; an init bit is 1 when rnd < P
IN_BITS  in  DI  incoming stochastic bits for this cycle
EM_OUT  in  1  selected bit returned from the edge memory
EM_IN  out  1  data bit to the edge memory
EM_EN  out  1  shift enable to the edge memory
EM_SEL  out  N  binary read index, zero-extended to N bits (upper bits 0)
OUT  out  1  registered stochastic output of the node
READY  out  1  high while in RUN

Behaviour:
- FSM states are IDLE, INIT and RUN.
- Reset (RESET=0, asynchronous) forces the following:
  - state=IDLE, init counter=0, LFSR=SEED
  - OUT=0, READY=0
  - EM_EN=0, EM_IN=0, EM_SEL=0
- Releasing reset is synchronous to CLK.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left with feedback into bit0.
  - Advances every cycle outside reset, in all states.
  - rnd = lfsr[W-1:0]; idx = lfsr[15:16-log2(N)].
- IDLE:
  - EM_EN=0, EM_IN=0, EM_SEL=0, OUT holds 0.
  - START=1 -> INIT with counter cleared.
- INIT (exactly N cycles):
  - EM_EN=1; EM_IN = (rnd < P) as an unsigned compare; counter increments each cycle.
  - When counter == N-1 -> RUN on the next edge.
  - P=0 gives all-0 init bits. P=2^W-1 gives 1 except when rnd equals all-ones.
  - OUT=0 throughout; EM_SEL=0.
- RUN:
  - agree = (&IN_BITS) | (~|IN_BITS).
  - EM_EN = agree; EM_IN = IN_BITS[0]; both combinational from IN_BITS.
  - EM_SEL = idx (registered, so it changes once per cycle).
  - OUT <= agree ? IN_BITS[0] : EM_OUT, giving 1-cycle latency.
  - READY=1.
- With DI=1, agree is always 1: EM_EN=1 every cycle and OUT follows IN_BITS[0] delayed by one cycle.
- START in INIT or RUN restarts INIT:
  - Counter clears and READY drops on the next edge.
  - OUT holds its last value during the first cycle, then is forced to 0.
- START coincident with the final INIT cycle: restart takes priority and the state stays INIT with counter=0.
- A reset mid-INIT or mid-RUN aborts immediately. No partial-state recovery; the edge memory contents are don't-care until the next INIT completes.
- The block never drives EM_EN in IDLE, so the edge memory is frozen.

Decomposition:
- Shared package stoch_pkg holds:
  - state encoding (IDLE=2'b00, INIT=2'b01, RUN=2'b10)
  - LFSR width and tap constants
  - clog2 function for the index width
- One natural sub-module, lfsr16, with ports CLK, RESET and seed parameter, output lfsr[15:0]. It is reusable by other stochastic nodes.
- FSM, init counter, agree logic and output register stay in em_edge_ctrl.

Test Plan:
- Reset then release with START=0 for 20 cycles -> EM_EN=0, OUT=0, READY=0, EM_SEL=0 throughout.
- N=8, P=8'h00, START pulse -> exactly 8 cycles of EM_EN=1 with EM_IN=0, then READY=1 on cycle 9; repeat with P=8'hFF -> EM_IN=1 except when rnd=8'hFF, matching a reference LFSR model from SEED.
- RUN, DI=2, IN_BITS=2'b11 then 2'b00 -> EM_EN=1, EM_IN=1 then 0; OUT=1 then 0, each one cycle later.
- RUN, IN_BITS=2'b01, EM_OUT driven 1 -> EM_EN=0, OUT=1 next cycle; EM_OUT=0 -> OUT=0; EM_SEL in 0..7 with bits[7:3]=0.
- START during RUN (and on the last INIT cycle) -> READY falls, 8 fresh INIT cycles of EM_EN=1, counter restarts at 0.
- RESET asserted asynchronously mid-INIT (between clock edges) -> OUT, READY, EM_EN go 0 immediately; LFSR returns to 16'hACE1.
